// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit.
// The FSM state enum and the NOP used as the reset instruction live here.
package mem_access_pkg;

    typedef enum logic [1:0] {
        Fetch   = 2'd0,
        Data    = 2'd1,
        Release = 2'd2
    } mem_access_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/register_d.sv
// Enable-gated D register with an asynchronous, active-high reset
// to a configurable value.
module register_d #(
    parameter int          N           = 32,
    parameter logic [N-1:0] reset_value = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= reset_value;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequences one instruction fetch plus an optional load/store per pipeline
// step on a single-port Wishbone-classic bus, stalling the core until done.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_SIZE-1:0]   inst_mem_addr,
    output logic [31:0]            inst,
    input  logic [DATA_SIZE-1:0]   data_mem_addr,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic [DATA_SIZE/8-1:0] byte_en,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   mem_busy,
    output logic                   cyc_o,
    output logic                   stb_o,
    output logic                   we_o,
    output logic [DATA_SIZE/8-1:0] sel_o,
    output logic [DATA_SIZE-1:0]   addr_o,
    output logic [DATA_SIZE-1:0]   dat_o,
    input  logic                   ack_i,
    input  logic [DATA_SIZE-1:0]   dat_i
);

    mem_access_state_t state_reg, state_next;
    logic              inst_en;
    logic              rd_data_en;
    logic [31:0]       inst_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= Fetch;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus outputs are gated by reset so an in-flight cycle is abandoned at once.
    always_comb begin
        state_next = state_reg;
        cyc_o      = 1'b0;
        stb_o      = 1'b0;
        we_o       = 1'b0;
        sel_o      = '0;
        addr_o     = '0;
        dat_o      = '0;
        inst_en    = 1'b0;
        rd_data_en = 1'b0;
        unique case (state_reg)
            Fetch: begin
                cyc_o  = !reset;
                stb_o  = !reset;
                sel_o  = reset ? '0 : '1;
                addr_o = reset ? '0 : inst_mem_addr;
                if (ack_i) begin
                    inst_en    = 1'b1;
                    state_next = (rd_en || wr_en) ? Data : Release;
                end
            end
            Data: begin
                cyc_o  = !reset;
                stb_o  = !reset;
                we_o   = !reset && wr_en;
                sel_o  = reset ? '0 : byte_en;
                addr_o = reset ? '0 : data_mem_addr;
                dat_o  = reset ? '0 : wr_data;
                if (ack_i) begin
                    // A simultaneous rd_en/wr_en is a store, so no capture.
                    rd_data_en = !wr_en;
                    state_next = Release;
                end
            end
            Release: begin
                state_next = Fetch;
            end
            default: begin
                state_next = Fetch;
            end
        endcase
    end

    assign mem_busy = (state_reg != Release);

    generate
        if (DATA_SIZE == 64) begin : g_inst_wide
            assign inst_d = inst_mem_addr[2] ? dat_i[63:32] : dat_i[31:0];
        end else begin : g_inst_narrow
            assign inst_d = dat_i[31:0];
        end
    endgenerate

    register_d #(
        .N           (32),
        .reset_value (NOP_INST)
    ) u_inst_reg (
        .clock (clock),
        .reset (reset),
        .en    (inst_en),
        .d     (inst_d),
        .q     (inst)
    );

    register_d #(
        .N           (DATA_SIZE),
        .reset_value ('0)
    ) u_rd_data_reg (
        .clock (clock),
        .reset (reset),
        .en    (rd_data_en),
        .d     (dat_i),
        .q     (rd_data)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit instance for the bus sequencing
// and a 64-bit instance for upper/lower instruction word selection.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // 32-bit instance
    logic [31:0] inst_mem_addr = '0;
    logic [31:0] inst;
    logic [31:0] data_mem_addr = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rd_data;
    logic        mem_busy;
    logic        cyc_o, stb_o, we_o;
    logic [3:0]  sel_o;
    logic [31:0] addr_o, dat_o;
    logic        ack_i = 1'b0;
    logic [31:0] dat_i = '0;

    // 64-bit instance
    logic [63:0] w_inst_mem_addr = '0;
    logic [31:0] w_inst;
    logic [63:0] w_rd_data;
    logic        w_mem_busy;
    logic        w_cyc_o, w_stb_o, w_we_o;
    logic [7:0]  w_sel_o;
    logic [63:0] w_addr_o, w_dat_o;
    logic        w_ack_i = 1'b0;
    logic [63:0] w_dat_i = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_access_unit #(.DATA_SIZE(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .inst_mem_addr (inst_mem_addr),
        .inst          (inst),
        .data_mem_addr (data_mem_addr),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .byte_en       (byte_en),
        .rd_data       (rd_data),
        .mem_busy      (mem_busy),
        .cyc_o         (cyc_o),
        .stb_o         (stb_o),
        .we_o          (we_o),
        .sel_o         (sel_o),
        .addr_o        (addr_o),
        .dat_o         (dat_o),
        .ack_i         (ack_i),
        .dat_i         (dat_i)
    );

    mem_access_unit #(.DATA_SIZE(64)) dut64 (
        .clock         (clock),
        .reset         (reset),
        .inst_mem_addr (w_inst_mem_addr),
        .inst          (w_inst),
        .data_mem_addr (64'h0),
        .rd_en         (1'b0),
        .wr_en         (1'b0),
        .wr_data       (64'h0),
        .byte_en       (8'h0),
        .rd_data       (w_rd_data),
        .mem_busy      (w_mem_busy),
        .cyc_o         (w_cyc_o),
        .stb_o         (w_stb_o),
        .we_o          (w_we_o),
        .sel_o         (w_sel_o),
        .addr_o        (w_addr_o),
        .dat_o         (w_dat_o),
        .ack_i         (w_ack_i),
        .dat_i         (w_dat_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Advance one clock: inputs change on the falling edge, checks follow at +1.
    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int low_cnt;

        // ---------------- reset state ----------------
        @(negedge clock);
        #1;
        check("rst_inst", {32'h0, inst}, 64'h13);
        check("rst_rd_data", {32'h0, rd_data}, 64'h0);
        check("rst_busy", {63'h0, mem_busy}, 64'h1);
        check("rst_cyc", {63'h0, cyc_o}, 64'h0);
        check("rst_w_cyc", {63'h0, w_cyc_o}, 64'h0);

        // ---------------- non-memory step, zero wait ----------------
        reset         = 1'b0;
        inst_mem_addr = 32'h100;
        ack_i         = 1'b1;
        dat_i         = 32'h0050_0093;
        w_inst_mem_addr = 64'h104;
        w_ack_i       = 1'b1;
        w_dat_i       = 64'hAAAA_AAAA_5555_5555;
        #1;
        check("nm_c1_addr", {32'h0, addr_o}, 64'h100);
        check("nm_c1_cyc", {63'h0, cyc_o}, 64'h1);
        check("nm_c1_we", {63'h0, we_o}, 64'h0);
        check("nm_c1_sel", {60'h0, sel_o}, 64'hF);
        check("nm_c1_busy", {63'h0, mem_busy}, 64'h1);
        next_cycle();
        ack_i   = 1'b0;
        dat_i   = 32'h0;
        w_ack_i = 1'b0;
        #1;
        check("nm_c2_busy", {63'h0, mem_busy}, 64'h0);
        check("nm_c2_inst", {32'h0, inst}, 64'h0050_0093);
        check("nm_c2_cyc", {63'h0, cyc_o}, 64'h0);
        check("w64_inst_hi", {32'h0, w_inst}, 64'hAAAA_AAAA);
        check("w64_busy", {63'h0, w_mem_busy}, 64'h0);
        next_cycle();
        #1;
        check("nm_c3_cyc", {63'h0, cyc_o}, 64'h1);
        check("nm_c3_busy", {63'h0, mem_busy}, 64'h1);

        // 64-bit instance: lower word selection on 8-byte aligned PC
        w_inst_mem_addr = 64'h100;
        w_ack_i         = 1'b1;
        w_dat_i         = 64'hAAAA_AAAA_5555_5555;

        // ---------------- load with two data wait states ----------------
        inst_mem_addr = 32'h104;
        data_mem_addr = 32'h2000;
        rd_en         = 1'b1;
        ack_i         = 1'b1;
        dat_i         = 32'h0000_2083;
        low_cnt       = 0;
        #1;
        check("ld_fetch_addr", {32'h0, addr_o}, 64'h104);
        next_cycle();
        w_ack_i = 1'b0;
        ack_i   = 1'b0;
        dat_i   = 32'h0;
        #1;
        check("w64_inst_lo", {32'h0, w_inst}, 64'h5555_5555);
        check("ld_data_addr", {32'h0, addr_o}, 64'h2000);
        check("ld_data_we", {63'h0, we_o}, 64'h0);
        check("ld_data_cyc", {63'h0, cyc_o}, 64'h1);
        check("ld_inst", {32'h0, inst}, 64'h0000_2083);
        if (!mem_busy) low_cnt++;
        next_cycle();
        #1;
        check("ld_wait2_addr", {32'h0, addr_o}, 64'h2000);
        if (!mem_busy) low_cnt++;
        next_cycle();
        ack_i = 1'b1;
        dat_i = 32'hDEAD_BEEF;
        #1;
        if (!mem_busy) low_cnt++;
        check("ld_ack_rd_data_held", {32'h0, rd_data}, 64'h0);
        next_cycle();
        ack_i = 1'b0;
        dat_i = 32'h0;
        rd_en = 1'b0;
        #1;
        check("ld_release_busy", {63'h0, mem_busy}, 64'h0);
        check("ld_rd_data", {32'h0, rd_data}, 64'hDEAD_BEEF);
        check("ld_busy_low_before_release", 64'(low_cnt), 64'h0);

        // ---------------- store ----------------
        next_cycle();
        inst_mem_addr = 32'h108;
        data_mem_addr = 32'h3000;
        wr_en         = 1'b1;
        byte_en       = 4'b0011;
        wr_data       = 32'h1234_ABCD;
        ack_i         = 1'b1;
        dat_i         = 32'h0011_2023;
        next_cycle();
        dat_i = 32'hFFFF_FFFF;
        #1;
        check("st_we", {63'h0, we_o}, 64'h1);
        check("st_sel", {60'h0, sel_o}, 64'h3);
        check("st_dat_o", {32'h0, dat_o}, 64'h1234_ABCD);
        check("st_addr", {32'h0, addr_o}, 64'h3000);
        next_cycle();
        // spurious ack during Release must capture nothing
        ack_i = 1'b1;
        dat_i = 32'hCAFE_F00D;
        #1;
        check("st_rd_data_kept", {32'h0, rd_data}, 64'hDEAD_BEEF);
        check("st_inst", {32'h0, inst}, 64'h0011_2023);
        check("rel_idle_dat_o", {32'h0, dat_o}, 64'h0);
        check("rel_idle_sel", {60'h0, sel_o}, 64'h0);
        check("rel_idle_addr", {32'h0, addr_o}, 64'h0);
        next_cycle();
        ack_i = 1'b0;
        dat_i = 32'h0;
        #1;
        check("spur_inst", {32'h0, inst}, 64'h0011_2023);
        check("spur_rd_data", {32'h0, rd_data}, 64'hDEAD_BEEF);
        check("spur_state_fetch", {32'h0, addr_o}, 64'h108);
        check("spur_busy", {63'h0, mem_busy}, 64'h1);

        // ---------------- rd_en and wr_en together is a store ----------------
        rd_en = 1'b1;
        ack_i = 1'b1;
        dat_i = 32'h0000_0033;
        next_cycle();
        dat_i = 32'h7777_7777;
        #1;
        check("rw_we", {63'h0, we_o}, 64'h1);
        next_cycle();
        ack_i = 1'b0;
        wr_en = 1'b0;
        byte_en = 4'h0;
        #1;
        check("rw_rd_data_kept", {32'h0, rd_data}, 64'hDEAD_BEEF);
        next_cycle();

        // ---------------- reset during a Data wait state ----------------
        inst_mem_addr = 32'h10C;
        data_mem_addr = 32'h4000;
        ack_i         = 1'b1;
        dat_i         = 32'h0000_4003;
        next_cycle();
        ack_i = 1'b0;
        #1;
        check("mr_data_cyc", {63'h0, cyc_o}, 64'h1);
        #1;
        reset = 1'b1;
        #1;
        check("mr_cyc", {63'h0, cyc_o}, 64'h0);
        check("mr_stb", {63'h0, stb_o}, 64'h0);
        check("mr_inst", {32'h0, inst}, 64'h13);
        check("mr_rd_data", {32'h0, rd_data}, 64'h0);
        check("mr_busy", {63'h0, mem_busy}, 64'h1);
        next_cycle();
        reset = 1'b0;
        rd_en = 1'b0;
        #1;
        check("mr_after_addr", {32'h0, addr_o}, 64'h10C);
        check("mr_after_we", {63'h0, we_o}, 64'h0);
        check("mr_after_cyc", {63'h0, cyc_o}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
